// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The optional perf counters are enabled with FETCH_PERF_EN.
package riscv_fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int FETCH_ILEN = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_e;

  typedef struct packed {
    logic                  filled;
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular reservation buffer: tail allocates, fill completes in order,
// head retires. Extra pointer bit distinguishes full from empty.
module fetch_buffer
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN  = FETCH_XLEN,
  parameter int ILEN  = FETCH_ILEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic                     fill,
  input  logic [ILEN-1:0]          fill_data,
  input  logic                     free,
  input  logic                     flush,
  output logic [XLEN-1:0]          head_pc,
  output logic [ILEN-1:0]          head_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [$clog2(DEPTH):0]   filled
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]   head;
  logic [CW-1:0]   fptr;
  logic [CW-1:0]   tail;
  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [ILEN-1:0] ins_q [DEPTH];

  assign count      = tail - head;
  assign inflight   = tail - fptr;
  assign filled     = fptr - head;
  assign head_pc    = pc_q[head[AW-1:0]];
  assign head_instr = ins_q[head[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      fptr <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      fptr <= '0;
      tail <= '0;
    end else begin
      if (alloc) begin
        pc_q[tail[AW-1:0]] <= alloc_pc;
        tail <= tail + CW'(1);
      end
      if (fill) begin
        ins_q[fptr[AW-1:0]] <= fill_data;
        fptr <= fptr + CW'(1);
      end
      if (free)
        head <= head + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RISC-V fetch stage: PC, imem request port, reservation buffer, redirect.
// Define FETCH_PERF_EN to add perf_fetched/perf_stall/perf_flushed.
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN  = FETCH_XLEN,
  parameter int ILEN  = FETCH_ILEN,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] initial_address,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] inst_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flushed,
`endif
  output logic            fetch_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(INST_BYTES - 1);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   filled;
  logic [CW:0]     reserved;
  logic            run;
  logic            redir;
  logic            full;
  logic            req_fire;
  logic            drop;
  logic            fill_en;
  logic            hs;

  // Pending discards still occupy memory, so they count against DEPTH.
  assign reserved = {1'b0, count} + {1'b0, discard_cnt};
  assign full     = (reserved >= (CW+1)'(DEPTH));
  assign run      = (state == RUN);
  assign redir    = run && redirect_valid;

  assign imem_req_valid = run && !halt && !redirect_valid && !full;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign drop    = imem_rsp_valid && (redir || discard_cnt != '0);
  assign fill_en = imem_rsp_valid && !drop;

  assign inst_valid = (filled != '0);
  assign hs         = inst_valid && inst_ready;

  fetch_buffer #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .alloc      (req_fire),
    .alloc_pc   (pc),
    .fill       (fill_en),
    .fill_data  (imem_rsp_data),
    .free       (hs),
    .flush      (redir),
    .head_pc    (inst_pc),
    .head_instr (instruction),
    .count      (count),
    .inflight   (inflight),
    .filled     (filled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= BOOT;
      pc               <= '0;
      discard_cnt      <= '0;
      fetch_misaligned <= 1'b0;
    end else begin
      fetch_misaligned <= redir && (redirect_target[1:0] != 2'b00);
      unique case (state)
        BOOT: begin
          pc    <= initial_address & ALIGN;
          state <= RUN;
        end
        RUN: begin
          if (redir)
            pc <= redirect_target & ALIGN;
          else if (req_fire)
            pc <= pc + XLEN'(INST_BYTES);
        end
        default: state <= BOOT;
      endcase
      // A response landing in the redirect cycle consumes one discard.
      if (redir)
        discard_cnt <= discard_cnt + inflight
                     - CW'(imem_rsp_valid);
      else if (drop)
        discard_cnt <= discard_cnt - CW'(1);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(hs);
      if (run && ((imem_req_valid && !imem_req_ready) || full))
        perf_stall <= perf_stall + 32'd1;
      perf_flushed <= perf_flushed + 32'(drop)
                    + (redir ? 32'(filled - CW'(hs)) : 32'd0);
    end
  end
`endif

endmodule
